// File: rtl/link_monitor.sv
// Link qualification monitor: synchronizes PHY signal detect, qualifies the link
// on consecutive good frames, and drops it on silence, error bursts or signal loss.
module link_monitor #(
  parameter int unsigned FRAME_TIMEOUT = 100_000,
  parameter int unsigned UP_FRAMES     = 4,
  parameter int unsigned ERR_WINDOW    = 1_000_000,
  parameter int unsigned ERR_LIMIT     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_detect,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic        link_ok,
  output logic        link_up,
  output logic        link_down,
  output logic [15:0] err_total
);

  typedef enum logic [1:0] {DOWN, QUALIFY, UP, SUSPECT} state_t;

  localparam logic [23:0] TIMEOUT  = 24'(FRAME_TIMEOUT);
  localparam logic [23:0] WIN_LAST = 24'(ERR_WINDOW - 1);
  localparam logic [4:0]  UP_CNT   = 5'(UP_FRAMES);
  localparam logic [8:0]  LIMIT    = 9'(ERR_LIMIT);

  state_t      state, state_next;
  logic        sig_meta, sig_sync;
  logic [3:0]  good_cnt, good_cnt_next;
  logic [23:0] frame_timer, win_cnt;
  logic [7:0]  win_err;
  logic [8:0]  win_err_inc;
  logic        link_ok_q;
  logic        good, timeout, in_link, wrap, err_hit;

  // An errored frame is never counted good, even when rx_valid is also high.
  assign good        = rx_valid & ~rx_err;
  assign timeout     = (frame_timer == TIMEOUT);
  assign in_link     = (state == UP) || (state == SUSPECT);
  assign wrap        = in_link && (win_cnt == WIN_LAST);
  assign win_err_inc = wrap ? 9'd1 : ({1'b0, win_err} + 9'd1);
  assign err_hit     = rx_err && in_link && (win_err_inc >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_meta <= 1'b0;
      sig_sync <= 1'b0;
    end else begin
      sig_meta <= sig_detect;
      sig_sync <= sig_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DOWN;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    case (state)
      DOWN: begin
        good_cnt_next = '0;
        if (sig_sync && good) begin
          good_cnt_next = 4'd1;
          state_next    = (UP_CNT == 5'd1) ? UP : QUALIFY;
        end
      end
      QUALIFY: begin
        if (!sig_sync || rx_err) begin
          state_next = DOWN;
        end else if (good) begin
          if (({1'b0, good_cnt} + 5'd1) >= UP_CNT) state_next = UP;
          else good_cnt_next = good_cnt + 4'd1;
        end else if (timeout) begin
          state_next = DOWN;
        end
      end
      UP: begin
        if (!sig_sync || err_hit)   state_next = DOWN;
        else if (!good && timeout)  state_next = SUSPECT;
      end
      SUSPECT: begin
        if (!sig_sync || err_hit)   state_next = DOWN;
        else if (good)              state_next = UP;
        else if (timeout)           state_next = DOWN;
      end
      default: state_next = DOWN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_timer <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      err_total   <= '0;
      link_ok_q   <= 1'b0;
    end else begin
      if ((state_next != state) || good || (state == DOWN)) frame_timer <= '0;
      else frame_timer <= frame_timer + 24'd1;

      if (!in_link || wrap) win_cnt <= '0;
      else win_cnt <= win_cnt + 24'd1;

      // Outside UP/SUSPECT the count is held clear, so entry from QUALIFY starts fresh.
      if (!in_link)    win_err <= '0;
      else if (rx_err) win_err <= win_err_inc[8] ? 8'hFF : win_err_inc[7:0];
      else if (wrap)   win_err <= '0;

      if (rx_err && (err_total != '1)) err_total <= err_total + 16'd1;

      link_ok_q <= link_ok;
    end
  end

  // Pulses compare against the previous link_ok, so UP<->SUSPECT is silent and
  // reset clears both sides together without a link_down.
  always_comb begin
    link_ok   = in_link;
    link_up   = link_ok & ~link_ok_q;
    link_down = ~link_ok & link_ok_q;
  end

endmodule

// File: tb/tb_link_monitor.sv
// Directed bench for link_monitor: per-cycle vector table plus multi-cycle sequences.
module tb_link_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_detect, rx_valid, rx_err;
  logic        link_ok, link_up, link_down;
  logic [15:0] err_total;

  int tests  = 0;
  int failed = 0;
  int exp_et = 0;

  typedef struct {
    logic        sig, v, e;
    logic        ok, up, down;
    logic [15:0] et;
  } vec_t;

  vec_t tbl[16];

  link_monitor #(
    .FRAME_TIMEOUT(16),
    .UP_FRAMES(4),
    .ERR_WINDOW(64),
    .ERR_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sig_detect(sig_detect),
    .rx_valid(rx_valid),
    .rx_err(rx_err),
    .link_ok(link_ok),
    .link_up(link_up),
    .link_down(link_down),
    .err_total(err_total)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic e);
    rx_valid = v;
    rx_err   = e;
    if (e) exp_et = (exp_et < 65535) ? exp_et + 1 : 65535;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    sig_detect = 1'b0;
    rx_valid   = 1'b0;
    rx_err     = 1'b0;
    exp_et     = 0;
    @(posedge clk);
    #1;
    check("reset_state", {13'd0, link_ok, link_up, link_down, err_total}, 32'd0);
    rst_n = 1'b1;
  endtask

  // Four back-to-back good frames from DOWN with sig_sync already high.
  task automatic qualify(input string name);
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check(name, {link_ok, link_up, link_down}, 3'b110);
  endtask

  initial begin
    //        sig   v     e     ok    up    down  et
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      sig_detect = tbl[i].sig;
      cyc(tbl[i].v, tbl[i].e);
      tests++;
      if ({link_ok, link_up, link_down, err_total} !== {tbl[i].ok, tbl[i].up, tbl[i].down, tbl[i].et}) begin
        failed++;
        $display("FAIL vec%0d: ok/up/down/et got %b%b%b/%0d expected %b%b%b/%0d", i,
                 link_ok, link_up, link_down, err_total,
                 tbl[i].ok, tbl[i].up, tbl[i].down, tbl[i].et);
      end
    end

    // Spaced qualification, then silence -> SUSPECT -> recovery -> silence -> DOWN.
    do_reset();
    sig_detect = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      cyc(1'b1, 1'b0);
      check($sformatf("qual_pulse%0d", p), {link_ok, link_up, link_down}, 3'b000);
      repeat (7) cyc(1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0);
    check("qual_up", {link_ok, link_up, link_down}, 3'b110);
    for (int k = 1; k < 20; k++) begin
      cyc(1'b0, 1'b0);
      check($sformatf("silent%0d", k), {link_ok, link_up, link_down}, 3'b100);
    end
    cyc(1'b1, 1'b0);
    check("suspect_recover", {link_ok, link_up, link_down}, 3'b100);
    for (int k = 1; k < 34; k++) begin
      cyc(1'b0, 1'b0);
      check($sformatf("silent2_%0d", k), {link_ok, link_up, link_down}, 3'b100);
    end
    cyc(1'b0, 1'b0);
    check("timeout_down", {link_ok, link_up, link_down}, 3'b001);
    cyc(1'b0, 1'b0);
    check("timeout_down_end", {link_ok, link_up, link_down}, 3'b000);

    // Error window: 2 errors, wrap with an error in the wrap cycle, then limit hit.
    qualify("win_qual");
    for (int k = 1; k <= 70; k++) begin
      cyc(k % 8 == 4, (k == 3) || (k == 5) || (k == 64) || (k == 66) || (k == 70));
      if (k == 65) check("win_wrap_still_up", {link_ok, link_up, link_down}, 3'b100);
      if (k == 69) check("win_two_new_up", {link_ok, link_up, link_down}, 3'b100);
      if (k == 70) check("win_limit_down", {link_ok, link_up, link_down}, 3'b001);
    end
    check("win_err_total", {16'd0, err_total}, exp_et);

    // Signal loss goes through the synchronizer: drop on the 3rd edge.
    qualify("sig_qual");
    sig_detect = 1'b0;
    cyc(1'b0, 1'b0);
    check("sig_fall_e1", {link_ok, link_down}, 2'b10);
    cyc(1'b0, 1'b0);
    check("sig_fall_e2", {link_ok, link_down}, 2'b10);
    cyc(1'b0, 1'b0);
    check("sig_fall_e3", {link_ok, link_down}, 2'b01);

    // Asynchronous reset mid-UP: outputs clear at once, no link_down afterwards.
    sig_detect = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);
    qualify("rst_qual");
    cyc(1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst", {13'd0, link_ok, link_up, link_down, err_total}, 32'd0);
    exp_et = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_no_pulse", {link_ok, link_up, link_down}, 3'b000);
    cyc(1'b0, 1'b0);
    check("post_rst_down", {link_ok, link_up, link_down}, 3'b000);

    // Saturation of the error total.
    do_reset();
    for (int i = 0; i < 65534; i++) cyc(1'b0, 1'b1);
    check("et_fffe", {16'd0, err_total}, 32'h0000_FFFE);
    cyc(1'b0, 1'b1);
    check("et_ffff", {16'd0, err_total}, 32'h0000_FFFF);
    repeat (5) cyc(1'b0, 1'b1);
    check("et_sat", {16'd0, err_total}, 32'h0000_FFFF);
    cyc(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
